// File: rtl/decoder_524_if.sv
// rtl/decoder_524_if.sv - select/enable inputs and decoded line outputs of decoder_524
interface decoder_524_if;
    logic [4:0] a;
    logic       sta;
    logic       stb;
    logic       stc;
    logic c0,  c1,  c2,  c3,  c4,  c5,  c6,  c7;
    logic c8,  c9,  c10, c11, c12, c13, c14, c15;
    logic c16, c17, c18, c19, c20, c21, c22, c23;

    modport master (
        output a, sta, stb, stc,
        input  c0,  c1,  c2,  c3,  c4,  c5,  c6,  c7,
               c8,  c9,  c10, c11, c12, c13, c14, c15,
               c16, c17, c18, c19, c20, c21, c22, c23
    );

    modport slave (
        input  a, sta, stb, stc,
        output c0,  c1,  c2,  c3,  c4,  c5,  c6,  c7,
               c8,  c9,  c10, c11, c12, c13, c14, c15,
               c16, c17, c18, c19, c20, c21, c22, c23
    );
endinterface

// File: rtl/decoder_524.sv
// rtl/decoder_524.sv - registered 5-to-24 line decoder with triple enable
module decoder_524 #(
    parameter int ACTIVE_LOW = 1
) (
    input logic          clk,
    input logic          rst,
    decoder_524_if.slave bus
);
    localparam logic INACT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic ACT   = ~INACT;

    logic [23:0] q;
    logic        en;

    assign en = bus.sta & ~bus.stb & ~bus.stc;

    // Addresses 24..31 match no line index, so they leave every line inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {24{INACT}};
        end else begin
            for (int i = 0; i < 24; i++) begin
                q[i] <= (en && bus.a == 5'(i)) ? ACT : INACT;
            end
        end
    end

    assign bus.c0  = q[0];
    assign bus.c1  = q[1];
    assign bus.c2  = q[2];
    assign bus.c3  = q[3];
    assign bus.c4  = q[4];
    assign bus.c5  = q[5];
    assign bus.c6  = q[6];
    assign bus.c7  = q[7];
    assign bus.c8  = q[8];
    assign bus.c9  = q[9];
    assign bus.c10 = q[10];
    assign bus.c11 = q[11];
    assign bus.c12 = q[12];
    assign bus.c13 = q[13];
    assign bus.c14 = q[14];
    assign bus.c15 = q[15];
    assign bus.c16 = q[16];
    assign bus.c17 = q[17];
    assign bus.c18 = q[18];
    assign bus.c19 = q[19];
    assign bus.c20 = q[20];
    assign bus.c21 = q[21];
    assign bus.c22 = q[22];
    assign bus.c23 = q[23];
endmodule

// File: tb/tb_decoder_524.sv
// tb/tb_decoder_524.sv - self-checking bench for decoder_524 in both polarities
module tb_decoder_524;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    decoder_524_if bl ();
    decoder_524_if bh ();

    decoder_524 #(.ACTIVE_LOW(1)) u_lo (.clk(clk), .rst(rst), .bus(bl.slave));
    decoder_524 #(.ACTIVE_LOW(0)) u_hi (.clk(clk), .rst(rst), .bus(bh.slave));

    always #5 clk = ~clk;

    logic [23:0] vec_l, vec_h;
    assign vec_l = {bl.c23, bl.c22, bl.c21, bl.c20, bl.c19, bl.c18, bl.c17, bl.c16,
                    bl.c15, bl.c14, bl.c13, bl.c12, bl.c11, bl.c10, bl.c9,  bl.c8,
                    bl.c7,  bl.c6,  bl.c5,  bl.c4,  bl.c3,  bl.c2,  bl.c1,  bl.c0};
    assign vec_h = {bh.c23, bh.c22, bh.c21, bh.c20, bh.c19, bh.c18, bh.c17, bh.c16,
                    bh.c15, bh.c14, bh.c13, bh.c12, bh.c11, bh.c10, bh.c9,  bh.c8,
                    bh.c7,  bh.c6,  bh.c5,  bh.c4,  bh.c3,  bh.c2,  bh.c1,  bh.c0};

    typedef struct {
        logic        r;
        logic [4:0]  a;
        logic        sa, sb, sc;
        logic [23:0] exp_lo;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] prev_lo;
    logic        have_prev = 1'b0;

    // Active-low view of the spec: the one line whose index equals a, only when enabled.
    function automatic logic [23:0] model(input logic r, input logic [4:0] a,
                                          input logic sa, input logic sb, input logic sc);
        logic [23:0] v;
        v = '0;
        if (!r && sa && !sb && !sc && a < 5'd24) v[a] = 1'b1;
        return ~v;
    endfunction

    task automatic check(input string name, input logic [23:0] exp_lo);
        total++;
        if (vec_l !== exp_lo) begin
            bad++;
            $display("FAIL %s low-active: got %h want %h", name, vec_l, exp_lo);
        end
        total++;
        if (vec_h !== ~exp_lo) begin
            bad++;
            $display("FAIL %s high-active: got %h want %h", name, vec_h, ~exp_lo);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [4:0] a,
                        input logic sa, input logic sb, input logic sc,
                        input logic [23:0] exp_lo);
        rst = r; bl.a = a; bl.sta = sa; bl.stb = sb; bl.stc = sc;
        bh.a = a; bh.sta = sa; bh.stb = sb; bh.stc = sc;
        #1;
        if (have_prev) check({name, "_hold"}, prev_lo);
        @(posedge clk);
        #1;
        check(name, exp_lo);
        prev_lo   = exp_lo;
        have_prev = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bl.a = '0; bl.sta = 1'b0; bl.stb = 1'b1; bl.stc = 1'b1;
        bh.a = '0; bh.sta = 1'b0; bh.stb = 1'b1; bh.stc = 1'b1;

        tbl.push_back('{1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 24'hFFFFDF});
        tbl.push_back('{1'b0, 5'd24, 1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd27, 1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd10, 1'b0, 1'b1, 1'b1, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 24'hFFFBFF});
        tbl.push_back('{1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 24'hFDFFFF});
        tbl.push_back('{1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 24'hFDFFFF});
        tbl.push_back('{1'b0, 5'd23, 1'b1, 1'b0, 1'b0, 24'h7FFFFF});
        tbl.push_back('{1'b0, 5'd23, 1'b0, 1'b0, 1'b0, 24'hFFFFFF});
        tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 24'hFFFFFE});

        foreach (tbl[i])
            step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].a, tbl[i].sa, tbl[i].sb,
                 tbl[i].sc, tbl[i].exp_lo);

        for (int n = 0; n < 24; n++)
            step($sformatf("sweep%0d", n), 1'b0, 5'(n), 1'b1, 1'b0, 1'b0,
                 model(1'b0, 5'(n), 1'b1, 1'b0, 1'b0));

        for (int k = 0; k < 300; k++) begin
            logic       r, sa, sb, sc;
            logic [4:0] a;
            r  = ($urandom_range(15) == 0);
            a  = 5'($urandom_range(31));
            sa = ($urandom_range(7) != 0);
            sb = ($urandom_range(7) == 0);
            sc = ($urandom_range(7) == 0);
            step($sformatf("rand%0d", k), r, a, sa, sb, sc, model(r, a, sa, sb, sc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
